// File: rtl/mux_arb_pkg.sv
// Shared sizes and FSM state encoding for the 16-way round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NREQ  = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mux.sv
// Team 16:1 single-bit mux: y = d[s].
module mux
    import mux_arb_pkg::*;
(
    output logic             y,
    input  logic [SEL_W-1:0] s,
    input  logic [NREQ-1:0]  d
);

    assign y = d[s];

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for a shared 16:1 mux with bounded hold time per grant.
//
//   state | meaning
//   IDLE  | no grant; picks the next requester from ptr when req != 0
//   GRANT | requester s owns the mux until it drops req or hits HOLD_MAX cycles
module mux16_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  d,
    output logic [SEL_W-1:0] s,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             y,
    output logic             y_vld
);

    localparam int                CNT_W     = 5;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    arb_state_t       state, state_nxt;
    logic [SEL_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_nxt;
    logic [SEL_W-1:0] s_nxt;
    logic [NREQ-1:0]  gnt_nxt;
    logic             busy_nxt;
    logic             armed;
    logic             mux_y;
    logic [SEL_W-1:0] pick;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NREQ-1:0]  r,
                                                 input logic [SEL_W-1:0] p);
        logic [2*NREQ-1:0] dbl;
        logic [NREQ-1:0]   rot;
        logic [SEL_W-1:0]  off;
        dbl = {r, r} >> p;
        rot = dbl[NREQ-1:0];
        off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        return p + off;
    endfunction

    assign pick = rr_pick(req, ptr);

    mux u_mux (
        .y (mux_y),
        .s (s),
        .d (d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        s_nxt     = s;
        gnt_nxt   = gnt;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (armed && (req != '0)) begin
                    state_nxt = GRANT;
                    s_nxt     = pick;
                    gnt_nxt   = NREQ'(1) << pick;
                    busy_nxt  = 1'b1;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (!req[s] || (hold_cnt == HOLD_LAST)) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = s + SEL_W'(1);
                end else begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // armed stays low for the first edge after reset, pushing the earliest grant to the second edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr      <= '0;
            hold_cnt <= '0;
            s        <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            y        <= 1'b0;
            y_vld    <= 1'b0;
            armed    <= 1'b0;
        end else begin
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            s        <= s_nxt;
            gnt      <= gnt_nxt;
            busy     <= busy_nxt;
            y        <= mux_y;
            y_vld    <= busy;
            armed    <= 1'b1;
        end
    end

endmodule

// File: doc/mux16_rr_arbiter.md
MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 4, SHALL set the maximum consecutive grant cycles per requester; legal range 1..16.
REQ-002 clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req  input  16  request vector; bit i set means requester i wants the shared 16:1 mux.
REQ-005 d  input  16  data vector; bit i is requester i's data bit.
REQ-006 s  output  4  registered mux select, equal to the index of the granted requester.
REQ-007 gnt  output  16  registered one-hot grant; all zero when no grant is active.
REQ-008 busy  output  1  registered; high while in state GRANT.
REQ-009 y  output  1  registered; mux output d[s] sampled one cycle after a GRANT cycle.
REQ-010 y_vld  output  1  registered; qualifies y.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-012 In IDLE with req==0, the block SHALL remain in IDLE with gnt=0, busy=0, and s holding its last value.
REQ-013 In IDLE with req!=0, the block SHALL select the first set bit scanning ptr, ptr+1, ..., ptr+15 (mod 16) and enter GRANT on the next edge with s=idx, gnt=1<<idx, busy=1, and hold_cnt=0.
REQ-014 In GRANT, hold_cnt SHALL increment by 1 each cycle in which the grant is retained.
REQ-015 In GRANT, the block SHALL release when req[s]==0 or hold_cnt==HOLD_MAX-1. On release: next state IDLE, gnt=0, busy=0, ptr=(s+1) mod 16 (15 wraps to 0).
REQ-016 Release SHALL always pass through one IDLE cycle, so there is a minimum 1-cycle gap between grants.
REQ-017 A new request arriving during GRANT SHALL NOT preempt the current grant.
REQ-018 A simultaneous req[s] deassertion and hold limit SHALL cause a single release, with ptr advanced once.
REQ-019 Each cycle, y SHALL load d[s] and y_vld SHALL load busy, giving a 1-cycle latency from a GRANT cycle to valid y.
REQ-020 When HOLD_MAX==1, every grant SHALL last exactly one cycle.
REQ-021 req bits SHALL be sampled synchronously; d is sampled only through the mux at s.

Reset
REQ-022 On rst=1, the block SHALL immediately (asynchronously) force state=IDLE, ptr=0, hold_cnt=0, s=0, gnt=0, busy=0, y=0, y_vld=0.
REQ-023 Reset asserted mid-GRANT SHALL abort the grant with no release bookkeeping, and arbitration SHALL restart from ptr=0.
REQ-024 After rst deasserts, the first grant SHALL occur no earlier than the second rising edge.

Structure
REQ-025 A shared package (mux_arb_pkg) SHALL hold NREQ=16, SEL_W=4, and the IDLE/GRANT state encoding.
REQ-026 The block SHALL instantiate the team's existing 16:1 mux module, mux (ports y, s, d), as its single sub-module for the d[s] selection.
REQ-027 Round-robin priority selection SHALL be implemented as a rotate / priority-encode / rotate-back function inside the block, not as a separate module.

Verification
REQ-028 Apply reset with req=16'h0000 for 5 cycles -> gnt=0, busy=0, s=0, y_vld=0 throughout.
REQ-029 Hold req=16'h0001 and d=16'h0001 with HOLD_MAX=4 -> gnt=16'h0001 for 4 cycles, then 1 idle cycle, then re-grant to 0; y=1 with y_vld one cycle after each grant cycle.
REQ-030 Hold req=16'hFFFF with HOLD_MAX=1 -> s sequence 0,1,2,...,15,0 with one idle cycle between grants; verify wrap from 15 to 0.
REQ-031 With req=16'h8001 and ptr=1 after the first grant -> next grant goes to 15, then 0.
REQ-032 During a grant to 3 (req=16'h0008), set req=16'h0018 -> no preemption; drop req[3] -> release, IDLE, then grant to 4.
REQ-033 Assert rst in the 2nd cycle of a grant to 7 -> outputs zero immediately; after release, req=16'h0080 is granted with s=7 starting from ptr=0.
